// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel field widths and arbiter state encoding.
package vga_pkg;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOR_W  = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pix_t;
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Two-requester pixel request bundle; master drives requests, slave returns ready.
interface vga_plot_arbiter_if;
   import vga_pkg::*;

   logic [1:0]              req_valid;
   logic [1:0][X_W-1:0]     req_x;
   logic [1:0][Y_W-1:0]     req_y;
   logic [1:0][COLOR_W-1:0] req_color;
   logic [1:0]              req_ready;

   modport master (output req_valid, req_x, req_y, req_color, input req_ready);
   modport slave  (input req_valid, req_x, req_y, req_color, output req_ready);
endinterface

// File: rtl/vga_plot_arbiter_rr_arb2.sv
// Two-way round-robin grant; combinational ready, last grant advances only on a transfer.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] ready
);
   logic       last_q;
   logic [1:0] grant;

   always_comb begin
      grant = valid;
      if (valid == 2'b11)
         grant = last_q ? 2'b01 : 2'b10;
   end

   assign ready = en ? grant : 2'b00;

   // last_q resets to 1 so requester 0 wins the first contention
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_q <= 1'b1;
      else if (|(valid & ready))
         last_q <= ready[1];
   end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates two pixel writers onto the vga_adapter port and runs a full-screen clear sweep.
// Request pixels appear one cycle after transfer; requests are stalled for the whole sweep.
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter int XMAX = SCREEN_W,
   parameter int YMAX = SCREEN_H
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr_start,
   input  logic [COLOR_W-1:0]  clr_color,
   vga_plot_arbiter_if.slave   req,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOR_W-1:0]  color_out,
   output logic                plot,
   output logic                busy,
   output logic                clr_done,
   output logic                range_err
);
   localparam int CX_W = $clog2(XMAX + 1);
   localparam int CY_W = $clog2(YMAX + 1);

   state_t              state, state_nxt;
   logic [CX_W-1:0]     cx;
   logic [CY_W-1:0]     cy;
   logic [COLOR_W-1:0]  clr_col;
   logic                arb_en;
   logic                last_pix;
   logic                xfer;
   logic                in_range;
   pix_t                sel_pix;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .en    (arb_en),
      .valid (req.req_valid),
      .ready (req.req_ready)
   );

   assign last_pix = (cx == CX_W'(XMAX - 1)) && (cy == CY_W'(YMAX - 1));
   assign xfer     = |(req.req_valid & req.req_ready);

   always_comb begin
      sel_pix = req.req_ready[1]
              ? '{x: req.req_x[1], y: req.req_y[1], color: req.req_color[1]}
              : '{x: req.req_x[0], y: req.req_y[0], color: req.req_color[0]};
      in_range = ({24'd0, sel_pix.x} < 32'(XMAX)) && ({25'd0, sel_pix.y} < 32'(YMAX));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
         ST_CLEAR: if (last_pix)  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // busy spans the clr_done cycle so it drops right after the final pixel
   always_comb begin
      arb_en = (state == ST_IDLE) && !clr_start;
      busy   = (state == ST_CLEAR) || clr_done;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_out     <= '0;
         y_out     <= '0;
         color_out <= '0;
         plot      <= 1'b0;
         clr_done  <= 1'b0;
         range_err <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         clr_col   <= '0;
      end else begin
         plot      <= 1'b0;
         clr_done  <= 1'b0;
         range_err <= 1'b0;
         if (state == ST_IDLE) begin
            if (clr_start) begin
               clr_col <= clr_color;
               cx      <= '0;
               cy      <= '0;
            end else if (xfer) begin
               if (in_range) begin
                  x_out     <= sel_pix.x;
                  y_out     <= sel_pix.y;
                  color_out <= sel_pix.color;
                  plot      <= 1'b1;
               end else begin
                  range_err <= 1'b1;
               end
            end
         end else begin
            x_out     <= X_W'(cx);
            y_out     <= Y_W'(cy);
            color_out <= clr_col;
            plot      <= 1'b1;
            if (last_pix) begin
               clr_done <= 1'b1;
               cx       <= '0;
               cy       <= '0;
            end else if (cx == CX_W'(XMAX - 1)) begin
               cx <= '0;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench: expected pixels are queued as stimulus is accepted and popped as plot pulses appear.
module tb_vga_plot_arbiter;
   import vga_pkg::*;

   localparam int XMAX = 160;
   localparam int YMAX = 120;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       clr;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr_start = 1'b0;
   logic [2:0] clr_color = 3'b000;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] color_out;
   logic       plot, busy, clr_done, range_err;

   vga_plot_arbiter_if rif ();

   vga_plot_arbiter #(.XMAX(XMAX), .YMAX(YMAX)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr_start (clr_start),
      .clr_color (clr_color),
      .req       (rif),
      .x_out     (x_out),
      .y_out     (y_out),
      .color_out (color_out),
      .plot      (plot),
      .busy      (busy),
      .clr_done  (clr_done),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   logic sweeping = 1'b0;
   logic last_g = 1'b1;
   int   clr_cnt = 0;
   int   re_exp = 0;
   int   re_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic cyc(input logic clr, input logic [2:0] cc, input logic [1:0] v,
                      input pix_t p0, input pix_t p1);
      logic [1:0] er;
      pix_t       p;
      @(negedge clk);
      clr_start         = clr;
      clr_color         = cc;
      rif.req_valid     = v;
      rif.req_x[0]      = p0.x;  rif.req_y[0] = p0.y;  rif.req_color[0] = p0.color;
      rif.req_x[1]      = p1.x;  rif.req_y[1] = p1.y;  rif.req_color[1] = p1.color;
      #1;
      er = 2'b00;
      if (!sweeping && !clr)
         er = (v == 2'b11) ? (last_g ? 2'b01 : 2'b10) : v;
      check("req_ready", 32'(rif.req_ready), 32'(er));
      if (clr && !sweeping) begin
         for (int yy = 0; yy < YMAX; yy++)
            for (int xx = 0; xx < XMAX; xx++)
               exp_q.push_back('{x: 8'(xx), y: 7'(yy), c: cc, clr: 1'b1,
                                 last: (xx == XMAX-1) && (yy == YMAX-1)});
         sweeping = 1'b1;
         clr_cnt  = 0;
      end
      if (|er) begin
         last_g = er[1];
         p = er[1] ? p1 : p0;
         if (int'(p.x) < XMAX && int'(p.y) < YMAX)
            exp_q.push_back('{x: p.x, y: p.y, c: p.color, clr: 1'b0, last: 1'b0});
         else
            re_exp++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, 2'b00, '0, '0);
   endtask

   // Output-side monitor: pops the scoreboard on each plot and checks hold/done/busy behaviour
   logic [7:0] px;
   logic [6:0] py;
   logic [2:0] pc;
   logic       prev_ok = 1'b0;
   logic       done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         prev_ok   = 1'b0;
         done_prev = 1'b0;
      end else begin
         if (plot) begin
            if (exp_q.size() == 0) begin
               check("unexpected_plot", 32'(plot), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("x_out", 32'(x_out), 32'(e.x));
               check("y_out", 32'(y_out), 32'(e.y));
               check("color_out", 32'(color_out), 32'(e.c));
               check("clr_done_at_pixel", 32'(clr_done), 32'(e.last));
               if (e.clr) clr_cnt++;
               if (e.last) sweeping = 1'b0;
            end
         end else begin
            check("clr_done_no_plot", 32'(clr_done), 32'(0));
            if (prev_ok) begin
               check("x_hold", 32'(x_out), 32'(px));
               check("y_hold", 32'(y_out), 32'(py));
               check("color_hold", 32'(color_out), 32'(pc));
            end
         end
         if (clr_done) check("busy_at_done", 32'(busy), 32'(1));
         if (done_prev) check("busy_after_done", 32'(busy), 32'(0));
         if (range_err) re_seen++;
         done_prev = clr_done;
         px = x_out; py = y_out; pc = color_out;
         prev_ok = 1'b1;
      end
   end

   task automatic check_reset_vals();
      check("rst_plot", 32'(plot), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_clr_done", 32'(clr_done), 32'(0));
      check("rst_range_err", 32'(range_err), 32'(0));
      check("rst_x", 32'(x_out), 32'(0));
      check("rst_y", 32'(y_out), 32'(0));
      check("rst_color", 32'(color_out), 32'(0));
   endtask

   task automatic run_sweep(input logic [1:0] v, input pix_t p0, input pix_t p1);
      int n;
      n = 0;
      while (sweeping && n < 20000) begin
         // a second clr_start mid-sweep must be ignored
         cyc(n == 100, 3'b111, v, p0, p1);
         if (n == 0) check("busy_in_sweep", 32'(busy), 32'(1));
         n++;
      end
      if (sweeping) check("sweep_timeout", 32'(sweeping), 32'(0));
   endtask

   initial begin
      int n;
      rif.req_valid = '0; rif.req_x = '0; rif.req_y = '0; rif.req_color = '0;
      #1 reset = 1'b0;
      #1 check_reset_vals();
      @(negedge clk); #2 reset = 1'b1;

      // contention straight after reset: grants 0,1,0,1
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 3'b000, 2'b11, '{x: 8'(30+i), y: 7'(40), color: 3'b001},
                                  '{x: 8'(50+i), y: 7'(60), color: 3'b110});
      idle(2);
      cyc(1'b0, 3'b000, 2'b01, '{x: 8'd10, y: 7'd20, color: 3'b101}, '0);
      idle(2);
      // range: x = XMAX, y = YMAX, then both edges just inside
      cyc(1'b0, 3'b000, 2'b01, '{x: 8'd160, y: 7'd5, color: 3'b011}, '0);
      idle(2);
      cyc(1'b0, 3'b000, 2'b10, '0, '{x: 8'd3, y: 7'd120, color: 3'b001});
      idle(2);
      cyc(1'b0, 3'b000, 2'b10, '0, '{x: 8'd159, y: 7'd119, color: 3'b111});
      idle(2);

      // clear together with two pending requests
      cyc(1'b1, 3'b010, 2'b11, '{x: 8'd1, y: 7'd2, color: 3'b100},
                               '{x: 8'd7, y: 7'd8, color: 3'b011});
      run_sweep(2'b11, '{x: 8'd1, y: 7'd2, color: 3'b100}, '{x: 8'd7, y: 7'd8, color: 3'b011});
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 3'b000, 2'b11, '{x: 8'd1, y: 7'd2, color: 3'b100},
                                  '{x: 8'd7, y: 7'd8, color: 3'b011});
      idle(3);

      // reset mid-sweep at pixel 500
      cyc(1'b1, 3'b001, 2'b00, '0, '0);
      n = 0;
      while (clr_cnt < 500 && n < 2000) begin
         idle(1);
         n++;
      end
      check("pixel500_reached", 32'(clr_cnt), 32'(500));
      #1 reset = 1'b0;
      #1 check_reset_vals();
      exp_q.delete();
      sweeping = 1'b0;
      last_g   = 1'b1;
      @(negedge clk); #2 reset = 1'b1;
      idle(2);

      cyc(1'b1, 3'b110, 2'b00, '0, '0);
      run_sweep(2'b00, '0, '0);
      idle(3);

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      check("range_err_count", 32'(re_seen), 32'(re_exp));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter XMAX, default 160, screen width in pixels; legal x is 0..XMAX-1.
REQ-002 Parameter YMAX, default 120, screen height in pixels; legal y is 0..YMAX-1.
REQ-003 clk  input  1  single system clock (CLOCK_50 domain); all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clr_start  input  1  single-cycle pulse requesting a full-screen clear.
REQ-006 clr_color  input  3  colour used by the clear sweep; sampled on an accepted clr_start.
REQ-007 req_valid  input  2  per-requester pixel request (index 0, 1).
REQ-008 req_x  input  2x8  per-requester x coordinate.
REQ-009 req_y  input  2x7  per-requester y coordinate.
REQ-010 req_color  input  2x3  per-requester colour.
REQ-011 req_ready  output  2  per-requester accept; a request transfers when valid and ready are both high in the same cycle.
REQ-012 x_out  output  8  pixel x to vga_adapter.
REQ-013 y_out  output  7  pixel y to vga_adapter.
REQ-014 color_out  output  3  pixel colour to vga_adapter.
REQ-015 plot  output  1  write strobe to vga_adapter.
REQ-016 busy  output  1  high while a clear sweep is in progress.
REQ-017 clr_done  output  1  one-cycle pulse after the last clear pixel is issued.
REQ-018 range_err  output  1  one-cycle pulse when an accepted request had x >= XMAX or y >= YMAX.

Function
REQ-019 The FSM SHALL have states IDLE and CLEAR; requester arbitration occurs only in IDLE.
REQ-020 IDLE -> CLEAR on clr_start; clr_start in IDLE takes priority over any pending request, and req_ready is 0 in that cycle.
REQ-021 In CLEAR, SHALL issue exactly XMAX*YMAX plot pulses, one per cycle, row-major: x increments first, wraps XMAX-1 -> 0 while incrementing y; the first pixel is (0,0), the last is (XMAX-1,YMAX-1).
REQ-022 CLEAR -> IDLE after the last pixel; clr_done SHALL pulse in the same cycle that the last pixel's plot is high.
REQ-023 clr_start while in CLEAR SHALL be ignored; the sweep neither restarts nor changes colour.
REQ-024 In CLEAR, req_ready SHALL be 2'b00.
REQ-025 In IDLE with no clr_start, req_ready SHALL be combinational: grant at most one requester per cycle.
REQ-026 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted most recently; a lone valid requester is always granted.
REQ-027 The last-grant register SHALL update only on a transfer.
REQ-028 Accepted in-range requests SHALL appear on x_out/y_out/color_out with plot=1 exactly one cycle after the transfer (latency 1); throughput is one pixel per cycle.
REQ-029 Accepted out-of-range requests SHALL be dropped: plot stays 0, range_err pulses one cycle after the transfer, and x_out/y_out/color_out hold.
REQ-030 x_out/y_out/color_out SHALL be registered and hold their last value when plot=0.
REQ-031 The clear counters SHALL be wide enough that XMAX-1 and YMAX-1 compare without overflow; req_x/req_y comparisons are unsigned.

Reset
REQ-032 Assertion of reset SHALL asynchronously force: state IDLE, plot 0, busy 0, clr_done 0, range_err 0, x_out 0, y_out 0, color_out 0, clear counters 0, and the last-grant register to 1 (requester 0 wins the first contention).
REQ-033 Reset mid-sweep SHALL abandon the clear with no clr_done pulse; a pending transfer is lost.
REQ-034 Deassertion SHALL be used synchronously; the first arbitration occurs on the first rising edge after release.

Structure
REQ-035 Screen dimensions (160, 120), colour width 3, and the state encoding SHALL live in the shared vga_pkg package.
REQ-036 The round-robin grant logic SHALL be one sub-module, rr_arb2 (2 requesters, registered last-grant, enable on transfer); the clear sweep counter stays inline.

Verification
REQ-037 Single request: req_valid=01, (10,20,3'b101) -> req_ready=01 in that cycle; next cycle plot=1, x_out=10, y_out=20, color_out=101.
REQ-038 Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; four plot pulses follow in the same order.
REQ-039 Clear: clr_start with clr_color=3'b010 -> busy high; 19200 consecutive plot pulses from (0,0) to (159,119), colour 010; clr_done coincides with pixel (159,119); busy low the next cycle.
REQ-040 Clear vs request: clr_start and req_valid=11 in the same cycle -> req_ready=00 for the whole sweep; the requests are served after clr_done.
REQ-041 Range: request (160,5) -> accepted; plot stays 0; range_err pulses once; outputs unchanged.
REQ-042 Reset mid-sweep at pixel 500 -> all outputs reach their reset values immediately; clr_done never pulses; a fresh clr_start restarts at (0,0).
